// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM stage (master) and the memory system (slave).
interface mem_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: big-endian load/store/LL/SC over a req/ack data bus.
// A bus access freezes the pipeline (stallreq) until ack or timeout; the
// completed result is presented in DONE for one unstalled cycle.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,          // active-high synchronous reset
    input  logic        valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] result_i,
    input  logic        en_wb_i,
    input  logic [4:0]  desReg_addr_i,
    input  logic        LLbit_i,
    input  logic        stall_i,
    mem_stage_if.master bus,
    output logic [31:0] result,
    output logic        en_wb,
    output logic [4:0]  desReg_addr,
    output logic        mem_LLbit_en,
    output logic        mem_LLbit_data,
    output logic        stallreq,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_LL  = 4'd9;
    localparam logic [3:0] OP_SC  = 4'd10;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  dest_q, dest_d;
    logic        en_lat_q, en_lat_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ok_q, ok_d;
    logic        bus_err_q, bus_err_d;

    logic        is_byte, is_half, is_word, is_rd, is_wr, is_sc;
    logic        misalign_c, start_c;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] done_result;

    // Decode the incoming op: access size, direction, alignment, lanes.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        is_rd   = 1'b0;
        is_wr   = 1'b0;
        is_sc   = 1'b0;
        case (mem_op_i)
            OP_LB, OP_LBU: begin is_byte = 1'b1; is_rd = 1'b1; end
            OP_LH, OP_LHU: begin is_half = 1'b1; is_rd = 1'b1; end
            OP_LW, OP_LL:  begin is_word = 1'b1; is_rd = 1'b1; end
            OP_SB:         begin is_byte = 1'b1; is_wr = 1'b1; end
            OP_SH:         begin is_half = 1'b1; is_wr = 1'b1; end
            OP_SW:         begin is_word = 1'b1; is_wr = 1'b1; end
            OP_SC:         begin is_word = 1'b1; is_sc = 1'b1; end
            default: ;
        endcase
        misalign_c = valid_i && ((is_half && addr_i[0]) ||
                                 (is_word && (addr_i[1:0] != 2'b00)));
        // An SC whose reservation is already lost never touches the bus.
        start_c = valid_i && !misalign_c && (is_rd || is_wr || (is_sc && LLbit_i));
        // Big-endian lanes: byte 0 of the word lives in bits [31:24].
        if (is_byte)
            sel_c = 4'b1000 >> addr_i[1:0];
        else if (is_half)
            sel_c = addr_i[1] ? 4'b0011 : 4'b1100;
        else
            sel_c = 4'b1111;
        if (is_wr || is_sc) begin
            if (is_byte)
                wdata_c = {4{store_data_i[7:0]}};
            else if (is_half)
                wdata_c = {2{store_data_i[15:0]}};
            else
                wdata_c = store_data_i;
        end else begin
            wdata_c = 32'h0;
        end
    end

    // Access FSM next state and latched transaction fields.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        op_d      = op_q;
        off_d     = off_q;
        dest_d    = dest_q;
        en_lat_d  = en_lat_q;
        rdata_d   = rdata_q;
        ok_d      = ok_q;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d  = ACCESS;
                    count_d  = 8'd0;
                    req_d    = 1'b1;
                    we_d     = is_wr || is_sc;
                    addr_d   = {addr_i[31:2], 2'b00};
                    sel_d    = sel_c;
                    wdata_d  = wdata_c;
                    op_d     = mem_op_i;
                    off_d    = addr_i[1:0];
                    dest_d   = desReg_addr_i;
                    en_lat_d = en_wb_i;
                    ok_d     = 1'b0;
                end
            end
            ACCESS: begin
                // Ack wins over timeout when both land on the same cycle.
                if (bus.bus_ack) begin
                    rdata_d = bus.bus_rdata;
                    ok_d    = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end else if (count_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    ok_d      = 1'b0;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    state_d   = DONE;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            DONE: begin
                if (!stall_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bus register update; reset clears everything, even mid-access.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            count_q   <= 8'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            sel_q     <= 4'h0;
            wdata_q   <= 32'h0;
            op_q      <= 4'h0;
            off_q     <= 2'b00;
            dest_q    <= 5'd0;
            en_lat_q  <= 1'b0;
            rdata_q   <= 32'h0;
            ok_q      <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            op_q      <= op_d;
            off_q     <= off_d;
            dest_q    <= dest_d;
            en_lat_q  <= en_lat_d;
            rdata_q   <= rdata_d;
            ok_q      <= ok_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Extract and extend the loaded lane for the completed instruction.
    always_comb begin
        case (off_q)
            2'd0:    lane_b = rdata_q[31:24];
            2'd1:    lane_b = rdata_q[23:16];
            2'd2:    lane_b = rdata_q[15:8];
            default: lane_b = rdata_q[7:0];
        endcase
        lane_h = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (op_q)
            OP_LB:        done_result = {{24{lane_b[7]}}, lane_b};
            OP_LBU:       done_result = {24'h0, lane_b};
            OP_LH:        done_result = {{16{lane_h[15]}}, lane_h};
            OP_LHU:       done_result = {16'h0, lane_h};
            OP_LW, OP_LL: done_result = rdata_q;
            OP_SC:        done_result = 32'd1;
            default:      done_result = 32'h0;
        endcase
        if (!ok_q)
            done_result = 32'h0;
    end

    // Stage outputs toward MEM/WB and the hazard unit.
    always_comb begin
        stallreq       = 1'b0;
        misalign       = 1'b0;
        result         = 32'h0;
        en_wb          = 1'b0;
        desReg_addr    = 5'd0;
        mem_LLbit_en   = 1'b0;
        mem_LLbit_data = 1'b0;
        if (!rst_n) begin
            case (state_q)
                IDLE: begin
                    misalign    = misalign_c;
                    result      = result_i;
                    desReg_addr = desReg_addr_i;
                    en_wb       = valid_i && en_wb_i;
                    if (misalign_c) begin
                        en_wb = 1'b0;
                    end else if (start_c) begin
                        stallreq = 1'b1;
                        en_wb    = 1'b0;
                    end else if (valid_i && is_sc) begin
                        // Failed SC: resolves here with no bus traffic.
                        result = 32'h0;
                    end
                end
                ACCESS: begin
                    stallreq    = 1'b1;
                    desReg_addr = dest_q;
                end
                DONE: begin
                    result         = done_result;
                    desReg_addr    = dest_q;
                    en_wb          = ok_q && en_lat_q &&
                                     !(op_q == OP_SB || op_q == OP_SH || op_q == OP_SW);
                    mem_LLbit_en   = ok_q && (op_q == OP_LL || op_q == OP_SC);
                    mem_LLbit_data = ok_q && (op_q == OP_LL);
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_wdata = wdata_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected
// retirement and bus transactions; monitors pop and compare.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i, store_data_i, result_i;
    logic        en_wb_i;
    logic [4:0]  desReg_addr_i;
    logic        LLbit_i, stall_i;
    logic [31:0] result;
    logic        en_wb;
    logic [4:0]  desReg_addr;
    logic        mem_LLbit_en, mem_LLbit_data, stallreq, misalign, bus_err;

    mem_stage_if bif();

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_op_i(mem_op_i),
        .addr_i(addr_i), .store_data_i(store_data_i), .result_i(result_i),
        .en_wb_i(en_wb_i), .desReg_addr_i(desReg_addr_i), .LLbit_i(LLbit_i),
        .stall_i(stall_i), .bus(bif), .result(result), .en_wb(en_wb),
        .desReg_addr(desReg_addr), .mem_LLbit_en(mem_LLbit_en),
        .mem_LLbit_data(mem_LLbit_data), .stallreq(stallreq),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        en, llen, lld, mis, chk_res;
        logic [4:0]  dest;
        int          id;
    } exp_t;
    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  sel;
        logic        we;
        int          id;
    } bexp_t;

    exp_t  exp_q[$];
    bexp_t bexp_q[$];
    int n_tests = 0, n_fail = 0;
    int ack_delay = 1, req_cnt = 0, req_total = 0, last_req_len = 0, err_total = 0;
    logic ack_en = 1'b1, ack_force = 1'b0;
    logic [31:0] rd_val = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] res, input logic en,
                            input logic [4:0] dest, input logic llen, input logic lld,
                            input logic mis, input logic chk_res);
        exp_t e;
        e.id = id; e.res = res; e.en = en; e.dest = dest;
        e.llen = llen; e.lld = lld; e.mis = mis; e.chk_res = chk_res;
        exp_q.push_back(e);
    endtask

    task automatic push_bus(input int id, input logic [31:0] addr, input logic [3:0] sel,
                            input logic we, input logic [31:0] wdata);
        bexp_t b;
        b.id = id; b.addr = addr; b.sel = sel; b.we = we; b.wdata = wdata;
        bexp_q.push_back(b);
    endtask

    // Bus slave model plus bus-side scoreboard.
    initial begin
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bif.bus_req) begin
                req_cnt++;
                req_total++;
                bif.bus_ack = ack_en && (req_cnt == ack_delay);
            end else begin
                if (req_cnt != 0) last_req_len = req_cnt;
                req_cnt = 0;
                bif.bus_ack = ack_force;
            end
            bif.bus_rdata = rd_val;
            if (bif.bus_req && bif.bus_ack) begin
                if (bexp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL bus_unexpected: got txn at %h expected none", bif.bus_addr);
                end else begin
                    bexp_t b;
                    b = bexp_q.pop_front();
                    check($sformatf("bus%0d.addr", b.id), bif.bus_addr, b.addr);
                    check($sformatf("bus%0d.sel", b.id), {28'h0, bif.bus_sel}, {28'h0, b.sel});
                    check($sformatf("bus%0d.we", b.id), {31'h0, bif.bus_we}, {31'h0, b.we});
                    check($sformatf("bus%0d.wdata", b.id), bif.bus_wdata, b.wdata);
                end
            end
            if (bus_err) err_total++;
        end
    end

    // Retirement monitor: an instruction leaves the stage on an unstalled cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n && valid_i && !stall_i && !stallreq) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL retire_unexpected: got result %h expected no retire", result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.chk_res)
                        check($sformatf("ret%0d.result", e.id), result, e.res);
                    check($sformatf("ret%0d.en_wb", e.id), {31'h0, en_wb}, {31'h0, e.en});
                    check($sformatf("ret%0d.dest", e.id), {27'h0, desReg_addr}, {27'h0, e.dest});
                    check($sformatf("ret%0d.llen", e.id), {31'h0, mem_LLbit_en}, {31'h0, e.llen});
                    check($sformatf("ret%0d.lldata", e.id), {31'h0, mem_LLbit_data}, {31'h0, e.lld});
                    check($sformatf("ret%0d.misalign", e.id), {31'h0, misalign}, {31'h0, e.mis});
                end
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] ri, input logic en, input logic [4:0] dest,
                         input logic llb);
        valid_i = 1'b1; mem_op_i = op; addr_i = addr; store_data_i = sd;
        result_i = ri; en_wb_i = en; desReg_addr_i = dest; LLbit_i = llb;
    endtask

    // Issue one instruction and hold it until it retires; returns stall cycles.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] ri, input logic en, input logic [4:0] dest,
                         input logic llb, output int stalls);
        bit done;
        @(posedge clk); #1;
        drive(op, addr, sd, ri, en, dest, llb);
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stallreq) stalls++;
            else if (!stall_i) begin done = 1'b1; break; end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL wait_retire: got no retire expected retire within 100 cycles");
        end
        @(posedge clk); #1;
        valid_i = 1'b0; mem_op_i = 4'd0;
    endtask

    initial begin
        int st, rt0, et0;
        bit seen;
        rst_n = 1'b1; stall_i = 1'b0;
        drive(4'd0, 32'h0, 32'h0, 32'hAAAA5555, 1'b1, 5'd9, 1'b0);
        repeat (2) @(negedge clk);
        check("rst.bus_req", {31'h0, bif.bus_req}, 32'h0);
        check("rst.bus_we", {31'h0, bif.bus_we}, 32'h0);
        check("rst.bus_sel", {28'h0, bif.bus_sel}, 32'h0);
        check("rst.bus_addr", bif.bus_addr, 32'h0);
        check("rst.bus_wdata", bif.bus_wdata, 32'h0);
        check("rst.bus_err", {31'h0, bus_err}, 32'h0);
        check("rst.stallreq", {31'h0, stallreq}, 32'h0);
        check("rst.en_wb", {31'h0, en_wb}, 32'h0);
        check("rst.result", result, 32'h0);
        check("rst.dest", {27'h0, desReg_addr}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0; valid_i = 1'b0;

        // LB sign-extend, ack in 2nd access cycle
        ack_delay = 2; rd_val = 32'h000000F0;
        push_bus(1, 32'h1000, 4'b0001, 1'b0, 32'h0);
        push_exp(1, 32'hFFFFFFF0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd1, 32'h1003, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0, st);
        check("lb.stall_cycles", st, 3);

        ack_delay = 1; rd_val = 32'h12F45678;
        push_bus(2, 32'h1000, 4'b0100, 1'b0, 32'h0);
        push_exp(2, 32'h000000F4, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd2, 32'h1001, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, st);

        rd_val = 32'h12348001;
        push_bus(3, 32'h1000, 4'b0011, 1'b0, 32'h0);
        push_exp(3, 32'hFFFF8001, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd3, 32'h1002, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0, st);

        rd_val = 32'h80011234;
        push_bus(4, 32'h1000, 4'b1100, 1'b0, 32'h0);
        push_exp(4, 32'h00008001, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd4, 32'h1000, 32'h0, 32'h0, 1'b1, 5'd8, 1'b0, st);

        ack_delay = 3; rd_val = 32'hDEADBEEF;
        push_bus(5, 32'h1004, 4'b1111, 1'b0, 32'h0);
        push_exp(5, 32'hDEADBEEF, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd5, 32'h1004, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, st);
        check("lw.stall_cycles", st, 4);

        // Stores: lane replication, no writeback even with en_wb_i=1
        ack_delay = 1;
        push_bus(6, 32'h2000, 4'b0011, 1'b1, 32'hABCDABCD);
        push_exp(6, 32'h0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd7, 32'h2002, 32'h0000ABCD, 32'h0, 1'b1, 5'd1, 1'b0, st);
        push_bus(7, 32'h2000, 4'b0100, 1'b1, 32'hA5A5A5A5);
        push_exp(7, 32'h0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd6, 32'h2001, 32'h123456A5, 32'h0, 1'b1, 5'd2, 1'b0, st);
        push_bus(8, 32'h2000, 4'b1111, 1'b1, 32'hCAFEF00D);
        push_exp(8, 32'h0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd8, 32'h2000, 32'hCAFEF00D, 32'h0, 1'b0, 5'd3, 1'b0, st);

        // LL then SC (reservation held), then SC with reservation lost
        rd_val = 32'h12345678;
        push_bus(9, 32'h40, 4'b1111, 1'b0, 32'h0);
        push_exp(9, 32'h12345678, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(4'd9, 32'h40, 32'h0, 32'h0, 1'b1, 5'd10, 1'b0, st);
        push_bus(10, 32'h40, 4'b1111, 1'b1, 32'h00000055);
        push_exp(10, 32'h1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(4'd10, 32'h40, 32'h00000055, 32'h0, 1'b1, 5'd11, 1'b1, st);
        rt0 = req_total;
        push_exp(11, 32'h0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd10, 32'h40, 32'h00000055, 32'h77, 1'b1, 5'd11, 1'b0, st);
        check("sc_fail.stall_cycles", st, 0);
        check("sc_fail.no_bus", req_total, rt0);

        // Misaligned accesses: flagged, no bus, no writeback
        push_exp(12, 32'h0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(4'd5, 32'h41, 32'h0, 32'h0, 1'b1, 5'd4, 1'b0, st);
        check("lw_mis.stall_cycles", st, 0);
        push_exp(13, 32'h0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(4'd7, 32'h2003, 32'h1234, 32'h0, 1'b1, 5'd4, 1'b0, st);
        @(negedge clk);
        check("mis.no_bus", req_total, rt0);

        // NONE and reserved opcodes pass through
        push_exp(14, 32'h11112222, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd0, 32'h41, 32'h0, 32'h11112222, 1'b1, 5'd7, 1'b0, st);
        push_exp(15, 32'h33334444, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd13, 32'h3, 32'h0, 32'h33334444, 1'b1, 5'd12, 1'b0, st);

        // valid_i=0: pass-through with writeback forced off
        @(posedge clk); #1;
        drive(4'd5, 32'h41, 32'h0, 32'h00003333, 1'b1, 5'd3, 1'b0);
        valid_i = 1'b0;
        @(negedge clk);
        check("inv.en_wb", {31'h0, en_wb}, 32'h0);
        check("inv.result", result, 32'h00003333);
        check("inv.stallreq", {31'h0, stallreq}, 32'h0);
        check("inv.misalign", {31'h0, misalign}, 32'h0);
        @(negedge clk);
        check("inv.no_bus", {31'h0, bif.bus_req}, 32'h0);

        // Timeout with downstream stall holding DONE
        ack_en = 1'b0; et0 = err_total;
        @(posedge clk); #1;
        stall_i = 1'b1;
        drive(4'd5, 32'h100, 32'h0, 32'h0, 1'b1, 5'd13, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_err) begin seen = 1'b1; break; end
        end
        check("to.bus_err_seen", {31'h0, seen}, 32'h1);
        check("to.stallreq", {31'h0, stallreq}, 32'h0);
        check("to.en_wb", {31'h0, en_wb}, 32'h0);
        check("to.bus_req_off", {31'h0, bif.bus_req}, 32'h0);
        @(negedge clk);
        check("to.err_pulse_end", {31'h0, bus_err}, 32'h0);
        check("to.hold_en_wb", {31'h0, en_wb}, 32'h0);
        check("to.hold_stallreq", {31'h0, stallreq}, 32'h0);
        check("to.req_len", last_req_len, 16);
        push_exp(16, 32'h0, 1'b0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        stall_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0; mem_op_i = 4'd0;
        @(negedge clk);
        check("to.err_count", err_total - et0, 1);

        // Ack on the very last allowed cycle counts as success
        ack_en = 1'b1; ack_delay = 16; rd_val = 32'h0BADF00D; et0 = err_total;
        push_bus(17, 32'h104, 4'b1111, 1'b0, 32'h0);
        push_exp(17, 32'h0BADF00D, 1'b1, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd5, 32'h104, 32'h0, 32'h0, 1'b1, 5'd14, 1'b0, st);
        check("lastack.stall_cycles", st, 17);
        check("lastack.no_err", err_total, et0);

        // Reset during the 2nd access cycle, then a late ack
        ack_en = 1'b0;
        @(posedge clk); #1;
        drive(4'd5, 32'h200, 32'h0, 32'h5A5A5A5A, 1'b1, 5'd15, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid.stallreq", {31'h0, stallreq}, 32'h0);
        check("rstmid.result", result, 32'h0);
        check("rstmid.dest", {27'h0, desReg_addr}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0; valid_i = 1'b0; ack_force = 1'b1;
        @(negedge clk);
        check("rstmid.bus_req", {31'h0, bif.bus_req}, 32'h0);
        check("rstmid.bus_addr", bif.bus_addr, 32'h0);
        @(negedge clk);
        check("rstmid.late_ack_req", {31'h0, bif.bus_req}, 32'h0);
        check("rstmid.late_ack_err", {31'h0, bus_err}, 32'h0);
        @(posedge clk); #1;
        ack_force = 1'b0; ack_en = 1'b1; ack_delay = 1; rd_val = 32'h01020304;
        push_bus(18, 32'h300, 4'b1111, 1'b0, 32'h0);
        push_exp(18, 32'h01020304, 1'b1, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd5, 32'h300, 32'h0, 32'h0, 1'b1, 5'd16, 1'b0, st);
        check("post_rst.stall_cycles", st, 2);

        repeat (2) @(negedge clk);
        check("exp_q.drained", exp_q.size(), 0);
        check("bexp_q.drained", bexp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum ACCESS cycles waited for bus_ack before abort (legal range 2..255).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-high (1 = reset).
REQ-004 Port: valid_i  in  1  EX/MEM holds a live instruction.
REQ-005 Port: mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11..15 treated as NONE.
REQ-006 Port: addr_i  in  32  effective byte address; store_data_i  in  32  rt value.
REQ-007 Port: result_i  in  32 / en_wb_i  in  1 / desReg_addr_i  in  5  EX result, write enable, destination register.
REQ-008 Port: LLbit_i  in  1  current LLbit, already forwarded from WB.
REQ-009 Port: stall_i  in  1  downstream freeze (ctrl stop[4]).
REQ-010 Port: bus_req, bus_we  out  1; bus_addr  out  32 (word aligned); bus_sel  out  4; bus_wdata  out  32; bus_ack  in  1; bus_rdata  in  32.
REQ-011 Port: result, en_wb, desReg_addr  out  32/1/5  toward MEM/WB; mem_LLbit_en, mem_LLbit_data  out  1 each.
REQ-012 Port: stallreq  out  1  stage requests pipeline freeze; misalign  out  1; bus_err  out  1 (one-cycle pulse).

Function
REQ-013 Byte order big-endian: addr[1:0]=0 -> bus_sel 1000, data[31:24]; 3 -> 0001, data[7:0]; halfword addr[1]=0 -> 1100, data[31:16].
REQ-014 Bus op: LB..LW, LL (read, bus_we=0); SB, SH, SW, SC with LLbit_i=1 (write, bus_we=1); store data replicated into all selected lanes.
REQ-015 Misalign: LH/LHU/SH with addr[0]=1, LW/SW/LL/SC with addr[1:0]!=0 -> misalign=1 combinationally, no bus access, en_wb=0, LLbit unchanged, stallreq=0.
REQ-016 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-017 IDLE: valid_i & bus op & !misalign -> stallreq=1 combinationally; next state ACCESS, latching address, sel, we, wdata, dest, op; count cleared.
REQ-018 ACCESS: bus_req=1 with latched fields stable; stallreq=1; count increments each cycle without ack.
REQ-019 ACCESS & bus_ack -> latch bus_rdata, go DONE; bus_req drops the same edge; no second request for one instruction.
REQ-020 ACCESS & count reaches TIMEOUT-1 without ack -> bus_err pulse 1 cycle, go DONE with en_wb=0, LLbit_en=0.
REQ-021 DONE: stallreq=0; outputs present completed result; stall_i=1 -> stay DONE holding outputs; stall_i=0 -> IDLE next edge.
REQ-022 Load extension: LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW/LL full word.
REQ-023 LL: result=loaded word, mem_LLbit_en=1, mem_LLbit_data=1 in DONE.
REQ-024 SC with LLbit_i=1: bus write, result=1, en_wb=1, mem_LLbit_en=1, mem_LLbit_data=0 in DONE.
REQ-025 SC with LLbit_i=0: no bus access, no stall, result=0, en_wb=en_wb_i, LLbit_en=0, same cycle.
REQ-026 Stores (SB/SH/SW): en_wb=0 in DONE.
REQ-027 NONE op or valid_i=0: combinational pass-through of result_i, en_wb_i, desReg_addr_i; LLbit_en=0; stallreq=0 (valid_i=0 forces en_wb=0).
REQ-028 bus_ack outside ACCESS ignored; bus_ack simultaneous with timeout cycle counts as ack (no bus_err).

Reset
REQ-029 rst_n=1 at any edge, incl. mid-ACCESS: state IDLE, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, count=0, latched data=0, bus_err=0, next cycle.
REQ-030 During reset, combinational outputs stallreq=0, misalign=0, mem_LLbit_en=0, en_wb=0, result=0, desReg_addr=0.

Verification
REQ-031 LB addr 0x1003, ack after 2 cycles, rdata 0x000000F0 -> stallreq 3 cycles, bus_sel 0001, result 0xFFFFFFF0, en_wb=1.
REQ-032 SH addr 0x2002, data 0x0000ABCD -> bus_we=1, bus_sel 0011, bus_wdata 0xABCDABCD, en_wb=0 in DONE.
REQ-033 LL addr 0x40 rdata 0x12345678, then SC LLbit_i=1 -> LL LLbit_en/data 1/1; SC writes, result 1, LLbit_data 0; repeat SC with LLbit_i=0 -> no bus_req, result 0, stallreq 0.
REQ-034 LW addr 0x41 -> misalign=1, bus_req stays 0, en_wb=0, stallreq=0.
REQ-035 LW never acked, TIMEOUT=16 -> bus_req 16 cycles, bus_err one pulse, en_wb=0, FSM back to IDLE when stall_i=0.
REQ-036 Reset asserted in 2nd ACCESS cycle -> bus_req 0 next cycle, state IDLE; late bus_ack ignored.
